// File: rtl/counter_2_pkg.sv
// Shared definitions for the 3-bit sequence counter: mode encodings, state type,
// and Gray/binary conversion helpers.
package counter_2_pkg;

    localparam int MODE_BIN_UP = 0;
    localparam int MODE_BIN_DN = 1;
    localparam int MODE_GRAY   = 2;

    typedef logic [2:0] cnt3_t;

    function automatic cnt3_t bin2gray(input cnt3_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic cnt3_t gray2bin(input cnt3_t gray);
        cnt3_t bin;
        bin[2] = gray[2];
        bin[1] = bin[2] ^ gray[1];
        bin[0] = bin[1] ^ gray[0];
        return bin;
    endfunction

endpackage

// File: rtl/counter_2_next.sv
// Combinational next-state logic for the 3-bit sequence counter.
// Every 3-bit encoding lies on the cycle in every mode, so no recovery logic is needed.
module counter_2_next
    import counter_2_pkg::*;
#(
    parameter int MODE = MODE_BIN_UP
) (
    input  cnt3_t s,
    output cnt3_t s_next
);

    // NOTE: combinational outputs get a default first so no path can infer a latch.
    always_comb begin
        s_next = s + 3'd1;
        case (MODE)
            MODE_BIN_DN: s_next = s - 3'd1;
            MODE_GRAY:   s_next = bin2gray(gray2bin(s) + 3'd1);
            default:     s_next = s + 3'd1;
        endcase
    end

endmodule

// File: rtl/counter_2.sv
// Free-running 3-bit sequence counter: async-reset state register with outputs
// taken straight from the register bits (a = MSB, c = LSB).
module counter_2
    import counter_2_pkg::*;
#(
    parameter int    MODE      = MODE_BIN_UP,
    parameter cnt3_t RESET_VAL = 3'b000
) (
    input  logic clk,
    input  logic rst_n,
    output logic a,
    output logic b,
    output logic c
);

    cnt3_t s_q;
    cnt3_t s_d;

    counter_2_next #(
        .MODE (MODE)
    ) u_next (
        .s      (s_q),
        .s_next (s_d)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= RESET_VAL;
        end else begin
            s_q <= s_d;
        end
    end

    assign a = s_q[2];
    assign b = s_q[1];
    assign c = s_q[0];

endmodule

// File: tb/tb_counter_2.sv
// Self-checking bench for counter_2: five instances (up, down, Gray, up from 110,
// out-of-range mode) share clk/rst_n and are compared against a sequence model.
module tb_counter_2;

    localparam int N_INST = 5;

    logic              clk;
    logic              rst_n;
    logic [N_INST-1:0] a_o;
    logic [N_INST-1:0] b_o;
    logic [N_INST-1:0] c_o;

    int total;
    int bad;
    int steps;

    // Reference description of each instance, written independently of the RTL.
    int         inst_mode [N_INST] = '{0, 1, 2, 0, 3};
    logic [2:0] inst_rv   [N_INST] = '{3'b000, 3'b000, 3'b000, 3'b110, 3'b000};
    logic [2:0] gray_seq  [8]      = '{3'b000, 3'b001, 3'b011, 3'b010,
                                       3'b110, 3'b111, 3'b101, 3'b100};
    logic [2:0] prev_gray;

    counter_2 #(.MODE(0), .RESET_VAL(3'b000)) u_up   (.clk(clk), .rst_n(rst_n), .a(a_o[0]), .b(b_o[0]), .c(c_o[0]));
    counter_2 #(.MODE(1), .RESET_VAL(3'b000)) u_dn   (.clk(clk), .rst_n(rst_n), .a(a_o[1]), .b(b_o[1]), .c(c_o[1]));
    counter_2 #(.MODE(2), .RESET_VAL(3'b000)) u_gray (.clk(clk), .rst_n(rst_n), .a(a_o[2]), .b(b_o[2]), .c(c_o[2]));
    counter_2 #(.MODE(0), .RESET_VAL(3'b110)) u_up6  (.clk(clk), .rst_n(rst_n), .a(a_o[3]), .b(b_o[3]), .c(c_o[3]));
    counter_2 #(.MODE(3), .RESET_VAL(3'b000)) u_bad  (.clk(clk), .rst_n(rst_n), .a(a_o[4]), .b(b_o[4]), .c(c_o[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {a,b,c} after 'n' edges since reset release.
    function automatic logic [2:0] model(input int idx, input int n);
        int start;
        int pos;
        start = int'(inst_rv[idx]);
        case (inst_mode[idx])
            1: return 3'((start + 8 - (n % 8)) % 8);
            2: begin
                pos = 0;
                for (int k = 0; k < 8; k++) begin
                    if (gray_seq[k] == inst_rv[idx]) pos = k;
                end
                return gray_seq[(pos + n) % 8];
            end
            default: return 3'((start + n) % 8);
        endcase
    endfunction

    function automatic logic [2:0] observed(input int idx);
        return {a_o[idx], b_o[idx], c_o[idx]};
    endfunction

    task automatic check_all(input string tag, input bit after_edge);
        logic [2:0] obs;
        logic [2:0] exp_v;
        for (int i = 0; i < N_INST; i++) begin
            obs   = observed(i);
            exp_v = (rst_n === 1'b0) ? inst_rv[i] : model(i, steps);
            total++;
            assert (obs === exp_v) else begin
                bad++;
                $error("FAIL %s inst%0d steps=%0d observed=%b expected=%b", tag, i, steps, obs, exp_v);
            end
        end
        if (after_edge) begin
            obs = observed(2);
            total++;
            assert ($countones(obs ^ prev_gray) === 1) else begin
                bad++;
                $error("FAIL %s gray_hamming prev=%b observed=%b expected_distance=1", tag, prev_gray, obs);
            end
        end
        prev_gray = observed(2);
    endtask

    task automatic run_edges(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            steps++;
            #2;
            check_all(tag, 1'b1);
        end
    endtask

    // Called at posedge+2: pulls reset low mid-cycle, checks the immediate
    // response, holds for a few cycles, then releases on a falling edge.
    task automatic async_reset(input string tag, input int offset, input int hold);
        #(offset);
        rst_n = 1'b0;
        #1;
        check_all(tag, 1'b0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check_all(tag, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        steps = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        steps = 0;
        prev_gray = 3'b000;
        rst_n = 1'b0;

        #50;
        check_all("reset_hold", 1'b0);
        #45;
        check_all("reset_hold_late", 1'b0);
        #5;
        rst_n = 1'b1;

        // Two full periods from release, then advance the up counter to 101.
        run_edges("sequence", 16);
        run_edges("to_101", 5);
        async_reset("midcount_reset", 2, 1);
        run_edges("after_midcount", 3);

        // Random run lengths interrupted by resets at random points in the cycle.
        for (int r = 0; r < 8; r++) begin
            run_edges("random_run", int'($urandom_range(1, 20)));
            async_reset("random_reset", int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));
        end
        run_edges("final_run", 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
